// File: rtl/mskaes_param_fsm_if.sv
// Control/handshake bundle between the masked-AES round sequencer and its datapath.
interface mskaes_param_fsm_if;
  logic       valid_in;
  logic       in_ready;
  logic       key_mode;
  logic       busy;
  logic       cipher_valid;
  logic       out_ready;
  logic       in_ready_rnd;
  logic       global_init;
  logic       state_init;
  logic       KH_init;
  logic       state_enable;
  logic       state_en_MC;
  logic       state_en_loop;
  logic       enable_key_add;
  logic       KH_enable;
  logic       KH_loop;
  logic       KH_add_from_sb;
  logic       KH_rot_en;
  logic       rcon_rst;
  logic       rcon_update;
  logic       sbox_valid_in;
  logic       feed_sb_key;
  logic [3:0] round_idx;

  modport master (
    output valid_in, key_mode, out_ready,
    input  in_ready, busy, cipher_valid, in_ready_rnd,
    input  global_init, state_init, KH_init,
    input  state_enable, state_en_MC, state_en_loop, enable_key_add,
    input  KH_enable, KH_loop, KH_add_from_sb, KH_rot_en,
    input  rcon_rst, rcon_update, sbox_valid_in, feed_sb_key, round_idx
  );

  modport slave (
    input  valid_in, key_mode, out_ready,
    output in_ready, busy, cipher_valid, in_ready_rnd,
    output global_init, state_init, KH_init,
    output state_enable, state_en_MC, state_en_loop, enable_key_add,
    output KH_enable, KH_loop, KH_add_from_sb, KH_rot_en,
    output rcon_rst, rcon_update, sbox_valid_in, feed_sb_key, round_idx
  );
endinterface

// File: rtl/mskaes_param_fsm.sv
// Round sequencer for a masked AES core with NSB Sboxes per cycle and SB_LAT-cycle Sbox latency.
module mskaes_param_fsm #(
  parameter int unsigned NSB    = 4,
  parameter int unsigned SB_LAT = 4
) (
  input logic              clk,
  input logic              rst,
  mskaes_param_fsm_if.slave bus
);

  localparam int unsigned KC = 4 / NSB;
  localparam int unsigned SC = 16 / NSB;
  localparam int unsigned L  = KC + SC + SB_LAT;

  localparam logic [5:0] KC_C      = 6'(KC);
  localparam logic [5:0] SBOX_END  = 6'(KC + SC);
  localparam logic [5:0] RND_END   = 6'(KC + SC - 1);
  localparam logic [5:0] KH_START  = 6'(SB_LAT);
  localparam logic [5:0] KH_END    = 6'(SB_LAT + KC);
  localparam logic [5:0] ST_START  = 6'(KC + SB_LAT);
  localparam logic [5:0] LAST_CNT  = 6'(L - 1);

  generate
    if (!((NSB == 1) || (NSB == 2) || (NSB == 4)) || (SB_LAT < 1) || (SB_LAT > 15)) begin : g_bad_param
      $error("mskaes_param_fsm: illegal NSB/SB_LAT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  state_t     state, state_nx;
  logic [5:0] cnt, cnt_nx;
  logic [3:0] rnd, rnd_nx;
  logic       mode_r, mode_nx;

  logic [3:0] nr;
  logic       last_cnt, last_rnd, rot, st_win, kh_win;

  assign nr       = mode_r ? 4'd14 : 4'd10;
  assign last_cnt = (cnt == LAST_CNT);
  assign last_rnd = (rnd == nr);
  // AES-256 only rotates/applies rcon on every other round key word.
  assign rot      = !mode_r || rnd[0];
  assign st_win   = (cnt >= ST_START);
  assign kh_win   = (cnt >= KH_START) && (cnt < KH_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rnd    <= '0;
      mode_r <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      rnd    <= rnd_nx;
      mode_r <= mode_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rnd_nx   = rnd;
    mode_nx  = mode_r;

    bus.in_ready       = 1'b0;
    bus.busy           = 1'b0;
    bus.cipher_valid   = 1'b0;
    bus.in_ready_rnd   = 1'b0;
    bus.global_init    = 1'b0;
    bus.state_init     = 1'b0;
    bus.KH_init        = 1'b0;
    bus.state_enable   = 1'b0;
    bus.state_en_MC    = 1'b0;
    bus.state_en_loop  = 1'b0;
    bus.enable_key_add = 1'b0;
    bus.KH_enable      = 1'b0;
    bus.KH_loop        = 1'b0;
    bus.KH_add_from_sb = 1'b0;
    bus.KH_rot_en      = 1'b0;
    bus.rcon_rst       = 1'b0;
    bus.rcon_update    = 1'b0;
    bus.sbox_valid_in  = 1'b0;
    bus.feed_sb_key    = 1'b0;
    bus.round_idx      = '0;

    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.valid_in) begin
          state_nx = LOAD;
          mode_nx  = bus.key_mode;
          cnt_nx   = '0;
          rnd_nx   = '0;
        end
      end
      LOAD: begin
        bus.busy           = 1'b1;
        bus.global_init    = 1'b1;
        bus.state_init     = 1'b1;
        bus.KH_init        = 1'b1;
        bus.enable_key_add = 1'b1;
        bus.rcon_rst       = 1'b1;
        bus.in_ready_rnd   = 1'b1;
        state_nx = ROUND;
        rnd_nx   = 4'd1;
        cnt_nx   = '0;
      end
      ROUND: begin
        bus.busy           = 1'b1;
        bus.round_idx      = rnd;
        bus.sbox_valid_in  = (cnt < SBOX_END);
        bus.feed_sb_key    = (cnt < KC_C);
        bus.KH_add_from_sb = kh_win;
        bus.KH_enable      = kh_win;
        bus.KH_loop        = kh_win;
        bus.state_enable   = st_win;
        bus.state_en_loop  = st_win;
        bus.enable_key_add = st_win;
        bus.state_en_MC    = st_win && !last_rnd;
        bus.KH_rot_en      = rot;
        bus.rcon_update    = last_cnt && rot;
        // Randomness is requested one cycle ahead of the Sbox issue window.
        bus.in_ready_rnd   = (cnt < RND_END) || (last_cnt && !last_rnd);
        if (last_cnt) begin
          cnt_nx = '0;
          if (last_rnd) begin
            state_nx = DONE;
            rnd_nx   = '0;
          end else begin
            rnd_nx = rnd + 4'd1;
          end
        end else begin
          cnt_nx = cnt + 6'd1;
        end
      end
      DONE: begin
        bus.busy         = 1'b1;
        bus.cipher_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mskaes_param_fsm.sv
// Directed bench for mskaes_param_fsm across three NSB/SB_LAT configurations.
module tb_mskaes_param_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mskaes_param_fsm_if b0 ();
  mskaes_param_fsm_if b1 ();
  mskaes_param_fsm_if b2 ();

  mskaes_param_fsm #(.NSB(4), .SB_LAT(4)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  mskaes_param_fsm #(.NSB(1), .SB_LAT(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mskaes_param_fsm #(.NSB(2), .SB_LAT(3)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  localparam logic [18:0] IRDY = 19'd1 << 18;
  localparam logic [18:0] BSY  = 19'd1 << 17;
  localparam logic [18:0] CV   = 19'd1 << 16;
  localparam logic [18:0] IRR  = 19'd1 << 15;
  localparam logic [18:0] GI   = 19'd1 << 14;
  localparam logic [18:0] SI   = 19'd1 << 13;
  localparam logic [18:0] KI   = 19'd1 << 12;
  localparam logic [18:0] SE   = 19'd1 << 11;
  localparam logic [18:0] SMC  = 19'd1 << 10;
  localparam logic [18:0] SL   = 19'd1 << 9;
  localparam logic [18:0] EKA  = 19'd1 << 8;
  localparam logic [18:0] KE   = 19'd1 << 7;
  localparam logic [18:0] KL   = 19'd1 << 6;
  localparam logic [18:0] KAS  = 19'd1 << 5;
  localparam logic [18:0] KRE  = 19'd1 << 4;
  localparam logic [18:0] RR   = 19'd1 << 3;
  localparam logic [18:0] RU   = 19'd1 << 2;
  localparam logic [18:0] SBV  = 19'd1 << 1;
  localparam logic [18:0] FSK  = 19'd1 << 0;
  localparam logic [18:0] SG   = SE | SMC | SL | EKA;
  localparam logic [18:0] KG   = KE | KL | KAS;

  logic [18:0] o0;
  assign o0 = {b0.in_ready, b0.busy, b0.cipher_valid, b0.in_ready_rnd,
               b0.global_init, b0.state_init, b0.KH_init,
               b0.state_enable, b0.state_en_MC, b0.state_en_loop, b0.enable_key_add,
               b0.KH_enable, b0.KH_loop, b0.KH_add_from_sb, b0.KH_rot_en,
               b0.rcon_rst, b0.rcon_update, b0.sbox_valid_in, b0.feed_sb_key};

  typedef struct {
    int          cyc;
    logic [18:0] exp;
    logic [3:0]  rnd;
  } vec_t;

  vec_t vt [13];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  int          idx, rc, cvn, lat, c, prev;
  logic [15:0] rotmask;
  logic [12:0] se10, mc9;
  logic        mc10;

  initial begin
    // NSB=4, SB_LAT=4 -> KC=1, SC=4, L=9; cycle k = k-th edge after acceptance.
    vt[0]  = '{0,  BSY | IRR | GI | SI | KI | EKA | RR, 4'd0};
    vt[1]  = '{1,  BSY | IRR | SBV | FSK | KRE,         4'd1};
    vt[2]  = '{2,  BSY | IRR | SBV | KRE,               4'd1};
    vt[3]  = '{4,  BSY | IRR | SBV | KRE,               4'd1};
    vt[4]  = '{5,  BSY | SBV | KG | KRE,                4'd1};
    vt[5]  = '{6,  BSY | SG | KRE,                      4'd1};
    vt[6]  = '{9,  BSY | SG | KRE | RU | IRR,           4'd1};
    vt[7]  = '{10, BSY | IRR | SBV | FSK | KRE,         4'd2};
    vt[8]  = '{87, BSY | SE | SL | EKA | KRE,           4'd10};
    vt[9]  = '{90, BSY | SE | SL | EKA | KRE | RU,      4'd10};
    vt[10] = '{91, BSY | CV,                            4'd0};
    vt[11] = '{92, BSY | CV,                            4'd0};
    vt[12] = '{111, BSY | CV,                           4'd0};

    rst = 1'b1;
    b0.valid_in = 1'b0; b0.key_mode = 1'b0; b0.out_ready = 1'b0;
    b1.valid_in = 1'b0; b1.key_mode = 1'b0; b1.out_ready = 1'b0;
    b2.valid_in = 1'b0; b2.key_mode = 1'b0; b2.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_state", 32'({o0, b0.round_idx}), 32'({IRDY, 4'd0}));
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'({o0, b0.round_idx}), 32'({IRDY, 4'd0}));

    // AES-128 run with key_mode and valid_in wiggled while busy.
    b0.key_mode = 1'b0; b0.valid_in = 1'b1;
    idx = 0; rc = 0; cvn = 0;
    for (int k = 0; k <= 111; k++) begin
      @(negedge clk);
      if (idx < 13 && vt[idx].cyc == k) begin
        check($sformatf("vecA[%0d]", idx), 32'({o0, b0.round_idx}), 32'({vt[idx].exp, vt[idx].rnd}));
        idx++;
      end
      if (b0.rcon_update) rc++;
      if (b0.cipher_valid) cvn++;
      b0.key_mode = k[0];
      b0.valid_in = k[1];
    end
    check("rcon_pulses_128", 32'(rc), 32'd10);
    check("cv_hold_cycles", 32'(cvn), 32'd21);

    b0.out_ready = 1'b1; b0.valid_in = 1'b1;
    @(negedge clk);
    check("drop_to_idle", 32'(o0), 32'(IRDY));
    b0.out_ready = 1'b0; b0.valid_in = 1'b0;
    @(negedge clk);
    check("no_load_after_drop", 32'(o0), 32'(IRDY));

    // AES-256 on the NSB=4 instance: 1+14*9 = 127.
    b0.key_mode = 1'b1; b0.valid_in = 1'b1;
    lat = -1; rc = 0;
    for (int k = 0; k <= 200; k++) begin
      @(negedge clk);
      if (k == 0) begin b0.valid_in = 1'b0; b0.key_mode = 1'b0; end
      if (b0.rcon_update) rc++;
      if (b0.cipher_valid) begin lat = k; break; end
    end
    check("latency_256_nsb4", 32'(lat), 32'd127);
    check("rcon_pulses_256_nsb4", 32'(rc), 32'd7);
    b0.out_ready = 1'b1;
    @(negedge clk);
    b0.out_ready = 1'b0;

    // Async reset at round 5, cnt 3 (cycle 1+4*9+3 = 40).
    b0.key_mode = 1'b0; b0.valid_in = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      b0.valid_in = 1'b0;
    end
    check("round5_cnt3", 32'({o0, b0.round_idx}), 32'({BSY | IRR | SBV | KRE, 4'd5}));
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", 32'({o0, b0.round_idx}), 32'({IRDY, 4'd0}));
    #1 rst = 1'b0;
    cvn = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (b0.cipher_valid) cvn++;
    end
    check("no_cv_after_abort", 32'(cvn), 32'd0);
    b0.valid_in = 1'b1;
    lat = -1;
    for (int k = 0; k <= 200; k++) begin
      @(negedge clk);
      b0.valid_in = 1'b0;
      if (b0.cipher_valid) begin lat = k; break; end
    end
    check("latency_after_reset", 32'(lat), 32'd91);
    b0.out_ready = 1'b1;
    @(negedge clk);
    b0.out_ready = 1'b0;

    // NSB=1, SB_LAT=4, AES-256: L=24, latency 1+14*24 = 337.
    b1.key_mode = 1'b1; b1.valid_in = 1'b1;
    lat = -1; rc = 0; rotmask = '0; prev = 0;
    for (int k = 0; k <= 400; k++) begin
      @(negedge clk);
      b1.valid_in = 1'b0;
      if (b1.round_idx != 4'(prev) && b1.round_idx != 4'd0 && b1.KH_rot_en)
        rotmask[b1.round_idx] = 1'b1;
      prev = int'(b1.round_idx);
      if (b1.rcon_update) rc++;
      if (b1.cipher_valid) begin lat = k; break; end
    end
    check("latency_256_nsb1", 32'(lat), 32'd337);
    check("rot_rounds_256", 32'(rotmask), 32'h2AAA);
    check("rcon_pulses_256_nsb1", 32'(rc), 32'd7);

    // NSB=2, SB_LAT=3, AES-128: L=13, latency 131; state_enable at cnt 5..12.
    b2.key_mode = 1'b0; b2.valid_in = 1'b1;
    lat = -1; se10 = '0; mc9 = '0; mc10 = 1'b0; prev = 0; c = 0;
    for (int k = 0; k <= 200; k++) begin
      @(negedge clk);
      b2.valid_in = 1'b0;
      if (b2.round_idx != 4'(prev)) c = 0; else c++;
      prev = int'(b2.round_idx);
      if (b2.round_idx == 4'd10 && c < 13) begin
        se10[c] = se10[c] | b2.state_enable;
        mc10    = mc10 | b2.state_en_MC;
      end
      if (b2.round_idx == 4'd9 && c < 13) mc9[c] = mc9[c] | b2.state_en_MC;
      if (b2.cipher_valid) begin lat = k; break; end
    end
    check("latency_128_nsb2", 32'(lat), 32'd131);
    check("se_window_round10", 32'(se10), 32'h1FE0);
    check("mc_window_round9", 32'(mc9), 32'h1FE0);
    check("mc_off_round10", 32'(mc10), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mskaes_param_fsm.md
MSKAES_PARAM_FSM -- requirements
Module: mskaes_param_fsm

Interface
REQ-001 Parameter NSB, default 4: number of byte Sboxes issued per cycle; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 Parameter SB_LAT, default 4: masked Sbox latency in cycles; legal 1..15; other values SHALL fail elaboration.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 valid_in  in  1  start request; in_ready  out  1  high only in IDLE.
REQ-006 key_mode  in  1  0=AES-128 (Nr=10), 1=AES-256 (Nr=14); sampled on acceptance only.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 cipher_valid  out  1  ciphertext valid; out_ready  in  1  consumer accepts.
REQ-009 in_ready_rnd  out  1  fresh Sbox randomness required in the next cycle.
REQ-010 global_init, state_init, KH_init  out  1 each  load-cycle strobes.
REQ-011 state_enable, state_en_MC, state_en_loop, enable_key_add  out  1 each  state datapath controls.
REQ-012 KH_enable, KH_loop, KH_add_from_sb, KH_rot_en  out  1 each  key datapath controls.
REQ-013 rcon_rst, rcon_update, sbox_valid_in, feed_sb_key  out  1 each  rcon and Sbox controls.
REQ-014 round_idx  out  4  current round, 1..Nr; 0 outside ROUND.

Function
REQ-015 Derived constants: KC=4/NSB, SC=16/NSB, L=KC+SC+SB_LAT cycles per round.
REQ-016 States: IDLE, LOAD, ROUND, DONE; cycle counter cnt counts 0..L-1 within ROUND.
REQ-017 IDLE->LOAD when valid_in && in_ready; key_mode latched into mode_r on the same edge.
REQ-018 LOAD lasts 1 cycle: global_init, state_init, KH_init, enable_key_add, rcon_rst and in_ready_rnd high; next state ROUND with round_idx=1, cnt=0.
REQ-019 ROUND, cnt<KC: sbox_valid_in=1, feed_sb_key=1.
REQ-020 ROUND, KC<=cnt<KC+SC: sbox_valid_in=1, feed_sb_key=0.
REQ-021 ROUND, SB_LAT<=cnt<SB_LAT+KC: KH_add_from_sb=1, KH_enable=1, KH_loop=1.
REQ-022 ROUND, KC+SB_LAT<=cnt<L: state_enable=1, state_en_loop=1, enable_key_add=1.
REQ-023 state_en_MC SHALL equal state_enable except in round Nr, where it is 0.
REQ-024 KH_rot_en=1 for AES-128 in all rounds; for AES-256 only in odd rounds (round_idx[0]=1).
REQ-025 rcon_update pulses at cnt=L-1 of every round in which KH_rot_en=1.
REQ-026 in_ready_rnd high in LOAD and in ROUND whenever cnt<KC+SC-1, or cnt=L-1 and round_idx<Nr.
REQ-027 At cnt=L-1: round_idx<Nr -> round_idx+1, cnt=0; round_idx=Nr -> DONE.
REQ-028 Latency: cipher_valid first high exactly 1+Nr*L cycles after the acceptance edge.
REQ-029 DONE: cipher_valid=1, all datapath strobes 0; cipher_valid held until out_ready=1, then IDLE on that edge.
REQ-030 valid_in outside IDLE SHALL be ignored; in DONE, valid_in together with out_ready only drops the ciphertext (no start); a start needs a new request in IDLE.
REQ-031 key_mode changes while busy SHALL have no effect; round count is fixed by mode_r.
REQ-032 Every output not named as high in a state/cnt window SHALL be 0.

Reset
REQ-033 rst high SHALL force IDLE, cnt=0, round_idx=0, mode_r=0 immediately, regardless of clk.
REQ-034 During and after reset until a new acceptance: in_ready=1; all other outputs 0.
REQ-035 Reset asserted in any state, including mid-ROUND or DONE, SHALL abort the operation with no cipher_valid pulse.

Verification
REQ-036 NSB=4, SB_LAT=4, key_mode=0, valid_in one cycle -> L=9; cipher_valid at cycle 91; 10 rcon_update pulses.
REQ-037 NSB=1, SB_LAT=4, key_mode=1 -> L=24, cipher_valid at cycle 337; KH_rot_en high in rounds 1,3,...,13 only; 7 rcon_update pulses.
REQ-038 NSB=2, SB_LAT=3, AES-128: round 10 -> state_enable high in cycles cnt=5..12, state_en_MC low throughout.
REQ-039 DONE with out_ready low for 20 cycles -> cipher_valid held 20+ cycles; out_ready=1 with valid_in=1 -> IDLE, no LOAD.
REQ-040 rst pulsed at round 5 cnt=3 (asynchronous, between edges) -> outputs 0 and in_ready=1 before the next edge; next valid_in runs a full-latency operation.
REQ-041 key_mode toggled every cycle during a key_mode=0 run -> cipher_valid still at 1+10*L.
